rh_axi4_wr_master: RTL

RH_AXI4_WR_MASTER -- requirements
Module: rh_axi4_wr_master

---
 rtl/rh_axi4_vip_pkg.sv | 51 +++++
 rtl/rh_axi4_len_fifo.sv | 61 ++++++
 rtl/rh_axi4_wr_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rh_axi4_vip_pkg.sv
// ---------------------------------------------------------------------------
// rh_axi4_vip -- shared types for the AXI4 write master.
//   rh_axi4_wcmd_t  : burst command  {addr, len, size, burst, id}
//   rh_axi4_wbeat_t : write beat     {data, strb}
//   rh_axi4_wrsp_t  : write response {id, resp}
//   RESP_*          : AXI response codes
//   rh_axi4_wstate_e: W engine states
// The struct widths follow the default module parameters. A master built
// with other widths gets matching struct types through its type parameters.
// ---------------------------------------------------------------------------
package rh_axi4_vip;

  localparam int RH_AXI4_AW = 32;
  localparam int RH_AXI4_DW = 32;
  localparam int RH_AXI4_IW = 4;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef struct packed {
    logic [RH_AXI4_AW-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [RH_AXI4_IW-1:0] id;
  } rh_axi4_wcmd_t;

  typedef struct packed {
    logic [RH_AXI4_DW-1:0]   data;
    logic [RH_AXI4_DW/8-1:0] strb;
  } rh_axi4_wbeat_t;

  typedef struct packed {
    logic [RH_AXI4_IW-1:0] id;
    logic [1:0]            resp;
  } rh_axi4_wrsp_t;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } rh_axi4_wstate_e;

  // A requested beat size can never exceed the bus width.
  function automatic logic [2:0] rh_axi4_clip_size(input logic [2:0] size,
                                                   input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/rh_axi4_len_fifo.sv
// ---------------------------------------------------------------------------
// rh_axi4_len_fifo -- small in-order queue of burst lengths handed from the
// AW side to the W engine.
//   ACLK, ARESETN : clock, async active-low reset
//   push, din     : write an entry (ignored when full)
//   pop, dout     : read the head entry (dout valid while !empty)
//   full, empty   : occupancy flags
// ---------------------------------------------------------------------------
module rh_axi4_len_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge ACLK) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rh_axi4_wr_master.sv
// ---------------------------------------------------------------------------
// rh_axi4_wr_master -- AXI4 write master. Turns a command stream and a beat
// stream into AW/W bursts and forwards B responses.
//   ACLK, ARESETN         : clock, async active-low reset
//   cmd_valid/ready, cmd  : burst commands (addr, len, size, burst, id)
//   wd_valid/ready, wd    : write beats (data, strb)
//   rsp_valid/ready, rsp  : write responses (id, resp)
//   AW*, W*, B*           : AXI4 write channels
// cmd_t/beat_t/rsp_t must match AW/DW/IW; the defaults match the defaults.
// ---------------------------------------------------------------------------
module rh_axi4_wr_master
  import rh_axi4_vip::*;
#(
  parameter int  AW       = 32,
  parameter int  DW       = 32,
  parameter int  IW       = 4,
  parameter int  MAX_OUTS = 4,
  parameter type cmd_t    = rh_axi4_wcmd_t,
  parameter type beat_t   = rh_axi4_wbeat_t,
  parameter type rsp_t    = rh_axi4_wrsp_t
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  cmd_t          cmd,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  beat_t         wd,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output rsp_t          rsp,
  output logic          AWVALID,
  input  logic          AWREADY,
  output logic [AW-1:0] AWADDR,
  output logic [7:0]    AWLEN,
  output logic [2:0]    AWSIZE,
  output logic [1:0]    AWBURST,
  output logic [IW-1:0] AWID,
  output logic          WVALID,
  input  logic          WREADY,
  output logic [DW-1:0] WDATA,
  output logic [DW/8-1:0] WSTRB,
  output logic          WLAST,
  input  logic          BVALID,
  output logic          BREADY,
  input  logic [IW-1:0] BID,
  input  logic [1:0]    BRESP
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW / 8));
  localparam int         OW       = $clog2(MAX_OUTS + 1);

  logic            run;
  logic [OW-1:0]   outs;
  logic            cmd_acc;
  logic            b_hs;
  logic            q_full;
  logic            q_empty;
  logic            q_pop;
  logic [7:0]      q_dout;
  logic            w_acc;
  logic            last_acc;
  logic [7:0]      beat_cnt;
  logic [7:0]      cur_len;
  rh_axi4_wstate_e state;
  rh_axi4_wstate_e state_nxt;

  assign cmd_ready = run && (!AWVALID || AWREADY) && (outs < OW'(MAX_OUTS)) && !q_full;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign BREADY    = run && (!rsp_valid || rsp_ready);
  assign b_hs      = BVALID && BREADY;

  // Holds the handshake readies low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) run <= 1'b0;
    else          run <= 1'b1;
  end

  // Outstanding bursts; a B with nothing outstanding is forwarded but the
  // count stays at zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      outs <= '0;
    end else if (cmd_acc && !b_hs) begin
      outs <= outs + 1'b1;
    end else if (!cmd_acc && b_hs && (outs != '0)) begin
      outs <= outs - 1'b1;
    end
  end

  // AW stage: a single register slice, payload frozen while stalled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      AWVALID <= 1'b0;
      AWADDR  <= '0;
      AWLEN   <= '0;
      AWSIZE  <= '0;
      AWBURST <= '0;
      AWID    <= '0;
    end else if (cmd_acc) begin
      AWVALID <= 1'b1;
      AWADDR  <= cmd.addr;
      AWLEN   <= cmd.len;
      AWSIZE  <= rh_axi4_clip_size(cmd.size, MAX_SIZE);
      AWBURST <= cmd.burst;
      AWID    <= cmd.id;
    end else if (AWREADY) begin
      AWVALID <= 1'b0;
    end
  end

  rh_axi4_len_fifo #(
    .WIDTH (8),
    .DEPTH (MAX_OUTS)
  ) u_len_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (cmd_acc),
    .din     (cmd.len),
    .pop     (q_pop),
    .dout    (q_dout),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= W_IDLE;
    else          state <= state_nxt;
  end

  // W engine. On the last beat of a burst the next length is popped
  // directly so consecutive bursts stream without a gap.
  always_comb begin
    state_nxt = state;
    wd_ready  = 1'b0;
    q_pop     = 1'b0;
    w_acc     = 1'b0;
    last_acc  = 1'b0;
    case (state)
      W_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          state_nxt = W_BURST;
        end
      end
      W_BURST: begin
        wd_ready = !WVALID || WREADY;
        w_acc    = wd_valid && wd_ready;
        last_acc = w_acc && (beat_cnt == cur_len);
        if (last_acc) begin
          if (!q_empty) q_pop = 1'b1;
          else          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_cnt <= '0;
      cur_len  <= '0;
    end else if (q_pop) begin
      beat_cnt <= '0;
      cur_len  <= q_dout;
    end else if (w_acc) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // W output register; holds the beat until the slave takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      WVALID <= 1'b0;
      WDATA  <= '0;
      WSTRB  <= '0;
      WLAST  <= 1'b0;
    end else if (w_acc) begin
      WVALID <= 1'b1;
      WDATA  <= wd.data;
      WSTRB  <= wd.strb;
      WLAST  <= (beat_cnt == cur_len);
    end else if (WREADY) begin
      WVALID <= 1'b0;
      WLAST  <= 1'b0;
    end
  end

  // B response slice.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else if (b_hs) begin
      rsp_valid <= 1'b1;
      rsp.id    <= BID;
      rsp.resp  <= BRESP;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
